// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with the
// same load/op_ready handshake as the shift-add multiplier beside it.
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          op_ready,
  output logic          div_by_zero
);

  // Handshake: load is accepted only when busy=0 (IDLE or DONE); operands are
  // sampled on that edge. op_ready=1 marks quotient/remainder/div_by_zero valid
  // and holds until the next accepted load or rst.

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  // dvd_sh shifts dividend bits out of its MSB while quotient bits enter its
  // LSB, so after DW iterations it holds the quotient.
  logic [DW-1:0] dvd_sh;
  logic [VW-1:0] dvs;
  logic [VW-1:0] rem_r;
  logic [CW-1:0] cnt;
  logic          zero_pend;

  logic          accept;
  logic          last;
  logic [VW:0]   r_shift;
  logic          r_ge;
  logic [VW-1:0] rem_nxt;

  assign accept  = load && (state != CALC);
  assign last    = (cnt == '0);
  assign r_shift = {rem_r, dvd_sh[DW-1]};
  assign r_ge    = (r_shift >= {1'b0, dvs});
  // The carry bit only matters for the compare; the difference is < divisor.
  assign rem_nxt = r_ge ? (r_shift[VW-1:0] - dvs) : r_shift[VW-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept)         next_state = (divisor == '0) ? IDLE : CALC;
        else if (zero_pend) next_state = DONE;
      end
      CALC: if (last)   next_state = DONE;
      DONE: if (accept) next_state = (divisor == '0) ? IDLE : CALC;
      default:          next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == CALC);
    op_ready = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_sh      <= '0;
      dvs         <= '0;
      rem_r       <= '0;
      cnt         <= '0;
      zero_pend   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd_sh      <= dividend;
      dvs         <= divisor;
      rem_r       <= '0;
      cnt         <= CW'(DW - 1);
      zero_pend   <= (divisor == '0);
      div_by_zero <= 1'b0;
    end else if (state == CALC) begin
      dvd_sh <= {dvd_sh[DW-2:0], r_ge};
      rem_r  <= rem_nxt;
      cnt    <= cnt - 1'b1;
      if (last) begin
        quotient  <= {dvd_sh[DW-2:0], r_ge};
        remainder <= rem_nxt;
      end
    end else if ((state == IDLE) && zero_pend) begin
      // Divide by zero takes one wait cycle in IDLE, then lands in DONE.
      quotient    <= '1;
      remainder   <= '0;
      div_by_zero <= 1'b1;
      zero_pend   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed scenarios, exhaustive operand sweep and a
// randomized tail, all checked against plain floor/mod arithmetic.
module tb_seq_divider;
  localparam int DW = 8;
  localparam int VW = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          op_ready;
  logic          div_by_zero;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] prev_q = '0;
  logic [VW-1:0] prev_r = '0;

  always #5 clk = ~clk;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .op_ready    (op_ready),
    .div_by_zero (div_by_zero)
  );

  initial begin
    #5_000_000;
    $display("FAIL timeout: observed no finish, required finish within bound");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_q"},     32'(quotient),    0);
    chk({tag, "_r"},     32'(remainder),   0);
    chk({tag, "_busy"},  32'(busy),        0);
    chk({tag, "_rdy"},   32'(op_ready),    0);
    chk({tag, "_dbz"},   32'(div_by_zero), 0);
    chk({tag, "_state"}, 32'(dut.state),   32'(ST_IDLE));
  endtask

  // One operation from the load edge (edge 0). ign_at: edge at which a
  // stray load is pulsed; rst_at: edge at which rst aborts (0 = neither).
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input int ign_at, input int rst_at);
    int            lat;
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    lat = (b == 0) ? 1 : DW;
    eq  = (b == 0) ? {DW{1'b1}} : DW'(int'(a) / int'(b));
    er  = (b == 0) ? '0 : VW'(int'(a) % int'(b));
    dividend = a;
    divisor  = b;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    chk("rdy_drop", 32'(op_ready),    0);
    chk("dbz_drop", 32'(div_by_zero), 0);
    chk("busy_e0",  32'(busy),        32'(b != 0));
    for (int e = 1; e <= lat; e++) begin
      if (e == ign_at) begin
        dividend = 8'd10;
        divisor  = 4'd3;
        load     = 1'b1;
      end
      if (e == rst_at) rst = 1'b1;
      tick();
      load = 1'b0;
      rst  = 1'b0;
      if (e == rst_at) begin
        chk_reset_state("abort");
        prev_q = '0;
        prev_r = '0;
        return;
      end
      if (e < lat) begin
        chk("rdy_wait",  32'(op_ready),  0);
        chk("busy_wait", 32'(busy),      1);
        chk("q_hold",    32'(quotient),  32'(prev_q));
        chk("r_hold",    32'(remainder), 32'(prev_r));
      end else begin
        chk("rdy_done",  32'(op_ready),    1);
        chk("busy_done", 32'(busy),        0);
        chk("quotient",  32'(quotient),    32'(eq));
        chk("remainder", 32'(remainder),   32'(er));
        chk("dbz",       32'(div_by_zero), 32'(b == 0));
        prev_q = eq;
        prev_r = er;
      end
    end
  endtask

  task automatic done_gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("gap_rdy", 32'(op_ready),  1);
      chk("gap_q",   32'(quotient),  32'(prev_q));
      chk("gap_r",   32'(remainder), 32'(prev_r));
    end
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    chk_reset_state("reset");
    rst = 1'b0;
    tick();

    run_op(8'd200, 4'd7, 0, 0);
    run_op(8'd255, 4'd1, 0, 0);
    run_op(8'd5,   4'd9, 0, 0);
    run_op(8'd0,   4'd3, 0, 0);
    run_op(8'd255, 4'd15, 0, 0);
    done_gap(2);

    run_op(8'd100, 4'd0, 0, 0);
    done_gap(1);
    run_op(8'd9,   4'd2, 0, 0);

    run_op(8'd200, 4'd7, 3, 0);
    done_gap(1);

    run_op(8'd200, 4'd7, 0, 4);
    tick();
    chk_reset_state("idle_after_abort");
    run_op(8'd50,  4'd6, 0, 0);

    // rst and load together in DONE: rst wins
    dividend = 8'd77;
    divisor  = 4'd5;
    load     = 1'b1;
    rst      = 1'b1;
    tick();
    load = 1'b0;
    rst  = 1'b0;
    chk_reset_state("rst_vs_load");
    prev_q = '0;
    prev_r = '0;
    tick();
    chk_reset_state("rst_vs_load_hold");

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a[DW-1:0], b[VW-1:0], 0, 0);
        done_gap(int'($urandom_range(0, 1)));
      end
    end

    for (int k = 0; k < 300; k++) begin
      logic [DW-1:0] ra;
      logic [VW-1:0] rb;
      ra = DW'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
      run_op(ra, rb, 0, 0);
      done_gap(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
